dma_channel_scheduler: RTL and testbench

Multi-channel front end for the burst DMA engine. Accepts transfer descriptors (source, destination, length) from up to `NUM_CH` requesters and arbitrates between them round-robin. It issues one descriptor at a time to the single DMA engine, waits for the engine's `done`, then returns a per-channel completion pulse. It sits between the channel request logic and the DMA engine and is the only block that drives the engine's `start`.

---
 rtl/dma_channel_scheduler.sv | 166 ++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_scheduler.sv
// Round-robin front end for the burst DMA engine. It takes one descriptor from a channel,
// starts the engine, waits for done or a timeout, then sends a completion pulse to that channel.
module dma_channel_scheduler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              req_valid_i,
  output logic [NUM_CH-1:0]              req_ready_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_src_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_dst_i,
  input  logic [NUM_CH*LEN_WIDTH-1:0]    req_len_i,
  output logic [NUM_CH-1:0]              cpl_valid_o,
  output logic                           cpl_err_o,
  output logic                           dma_start_o,
  output logic [ADDR_WIDTH-1:0]          dma_src_o,
  output logic [ADDR_WIDTH-1:0]          dma_dst_o,
  output logic [LEN_WIDTH-1:0]           dma_len_o,
  input  logic                           dma_done_i,
  output logic                           busy_o,
  output logic [$clog2(NUM_CH)-1:0]      grant_id_o
);

  localparam int unsigned IdW  = $clog2(NUM_CH);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [IdW-1:0]  LastCh  = IdW'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StSettle, StWait, StCpl} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]        grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] src_arr [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst_arr [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_arr [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign src_arr[c] = req_src_i[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign dst_arr[c] = req_dst_i[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[c] = req_len_i[c*LEN_WIDTH +: LEN_WIDTH];
  end

  // First valid channel at or after rr_ptr_q, wrapping modulo NUM_CH.
  logic           win_found;
  logic [IdW-1:0] win_idx;
  logic [IdW-1:0] cand;
  int unsigned    cand_sum;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_sum  = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand_sum = 32'(rr_ptr_q) + i;
      if (cand_sum >= NUM_CH) begin
        cand_sum = cand_sum - NUM_CH;
      end
      cand = IdW'(cand_sum);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    cpl_valid_o = '0;
    cpl_err_o   = 1'b0;
    dma_start_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          req_ready_o[win_idx] = 1'b1;
          grant_d = win_idx;
          src_d   = src_arr[win_idx];
          dst_d   = dst_arr[win_idx];
          len_d   = len_arr[win_idx];
          err_d   = 1'b0;
          // A zero-length descriptor completes without ever starting the engine.
          state_d = (len_arr[win_idx] == '0) ? StCpl : StIssue;
        end
      end
      StIssue: begin
        dma_start_o = 1'b1;
        state_d     = StSettle;
      end
      StSettle: begin
        // The done from the previous transfer may still be high here, so it is ignored.
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (dma_done_i) begin
          err_d   = 1'b0;
          state_d = StCpl;
        end else begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
          if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
            err_d   = 1'b1;
            state_d = StCpl;
          end
        end
      end
      StCpl: begin
        cpl_valid_o[grant_q] = 1'b1;
        cpl_err_o            = err_q;
        rr_ptr_d             = (grant_q == LastCh) ? '0 : grant_q + 1'b1;
        state_d              = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign grant_id_o = grant_q;
  assign dma_src_o  = src_q;
  assign dma_dst_o  = dst_q;
  assign dma_len_o  = len_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler: single transfer, stale done, zero length,
// pointer skip, timeout, reset mid-WAIT and round-robin order.
module tb_dma_channel_scheduler;

  localparam int unsigned NumCh = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned LenW  = 4;
  localparam int unsigned Tmo   = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NumCh-1:0]       req_valid = '0;
  logic [NumCh*AddrW-1:0] req_src = '0;
  logic [NumCh*AddrW-1:0] req_dst = '0;
  logic [NumCh*LenW-1:0]  req_len = '0;
  logic                   dma_done = 1'b0;
  logic [NumCh-1:0]       req_ready;
  logic [NumCh-1:0]       cpl_valid;
  logic                   cpl_err;
  logic                   dma_start;
  logic [AddrW-1:0]       dma_src;
  logic [AddrW-1:0]       dma_dst;
  logic [LenW-1:0]        dma_len;
  logic                   busy;
  logic [1:0]             grant_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_channel_scheduler #(
    .NUM_CH    (NumCh),
    .ADDR_WIDTH(AddrW),
    .LEN_WIDTH (LenW),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_src_i  (req_src),
    .req_dst_i  (req_dst),
    .req_len_i  (req_len),
    .cpl_valid_o(cpl_valid),
    .cpl_err_o  (cpl_err),
    .dma_start_o(dma_start),
    .dma_src_o  (dma_src),
    .dma_dst_o  (dma_dst),
    .dma_len_o  (dma_len),
    .dma_done_i (dma_done),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] src, input logic [31:0] dst,
                        input logic [3:0] len);
    req_src[ch*AddrW +: AddrW] = src;
    req_dst[ch*AddrW +: AddrW] = dst;
    req_len[ch*LenW +: LenW]   = len;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy),      64'h0);
    chk({tag, "_ready"}, 64'(req_ready), 64'h0);
    chk({tag, "_cpl"},   64'(cpl_valid), 64'h0);
    chk({tag, "_err"},   64'(cpl_err),   64'h0);
    chk({tag, "_start"}, 64'(dma_start), 64'h0);
    chk({tag, "_src"},   64'(dma_src),   64'h0);
    chk({tag, "_dst"},   64'(dma_dst),   64'h0);
    chk({tag, "_len"},   64'(dma_len),   64'h0);
    chk({tag, "_grant"}, 64'(grant_id),  64'h0);
  endtask

  int         rr_exp [5] = '{0, 1, 2, 3, 0};
  logic [3:0] oh;

  initial begin
    // Power-on reset
    tick(2);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(1);

    // Single transfer on ch1, done 5 cycles after start
    set_ch(1, 32'h1000, 32'h2000, 4'd4);
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h2);
    chk("t1_busy_idle", 64'(busy), 64'h0);
    tick(1);
    req_valid = '0;
    chk("t1_start", 64'(dma_start), 64'h1);
    chk("t1_src", 64'(dma_src), 64'h1000);
    chk("t1_dst", 64'(dma_dst), 64'h2000);
    chk("t1_len", 64'(dma_len), 64'h4);
    chk("t1_grant", 64'(grant_id), 64'h1);
    chk("t1_busy", 64'(busy), 64'h1);
    chk("t1_ready_busy", 64'(req_ready), 64'h0);
    tick(1);
    chk("t1_start_once", 64'(dma_start), 64'h0);
    tick(3);
    chk("t1_no_cpl_early", 64'(cpl_valid), 64'h0);
    tick(1);
    dma_done = 1'b1;
    tick(1);
    chk("t1_cpl", 64'(cpl_valid), 64'h2);
    chk("t1_cpl_err", 64'(cpl_err), 64'h0);
    chk("t1_cpl_busy", 64'(busy), 64'h1);
    tick(1);
    chk("t1_idle_busy", 64'(busy), 64'h0);
    chk("t1_idle_cpl", 64'(cpl_valid), 64'h0);

    // Stale done: held high through ISSUE/SETTLE, dropped on WAIT entry
    set_ch(2, 32'h3000, 32'h4000, 4'd2);
    req_valid = 4'b0100;
    #1;
    chk("sd_ready", 64'(req_ready), 64'h4);
    tick(1);
    req_valid = '0;
    chk("sd_start", 64'(dma_start), 64'h1);
    chk("sd_src", 64'(dma_src), 64'h3000);
    tick(1);
    chk("sd_settle_cpl", 64'(cpl_valid), 64'h0);
    tick(1);
    chk("sd_wait0_cpl", 64'(cpl_valid), 64'h0);
    dma_done = 1'b0;
    tick(1);
    chk("sd_wait1_cpl", 64'(cpl_valid), 64'h0);
    chk("sd_wait1_busy", 64'(busy), 64'h1);
    tick(1);
    chk("sd_wait2_cpl", 64'(cpl_valid), 64'h0);
    dma_done = 1'b1;
    tick(1);
    chk("sd_cpl", 64'(cpl_valid), 64'h4);
    chk("sd_cpl_err", 64'(cpl_err), 64'h0);
    tick(1);
    chk("sd_idle", 64'(busy), 64'h0);

    // Zero-length on ch3: no start, completion one cycle after accept
    set_ch(3, 32'h5000, 32'h6000, 4'd0);
    req_valid = 4'b1000;
    #1;
    chk("z_ready", 64'(req_ready), 64'h8);
    tick(1);
    req_valid = '0;
    chk("z_no_start", 64'(dma_start), 64'h0);
    chk("z_cpl", 64'(cpl_valid), 64'h8);
    chk("z_err", 64'(cpl_err), 64'h0);
    chk("z_len", 64'(dma_len), 64'h0);
    chk("z_grant", 64'(grant_id), 64'h3);
    chk("z_src", 64'(dma_src), 64'h5000);
    tick(1);
    chk("z_idle", 64'(busy), 64'h0);
    chk("z_cpl_done", 64'(cpl_valid), 64'h0);

    // Pointer skip: ch0 served, then ch0+ch2 valid -> ch2 first, ch1 skipped
    set_ch(0, 32'h7000, 32'h8000, 4'd1);
    req_valid = 4'b0001;
    #1;
    chk("ps_ready0", 64'(req_ready), 64'h1);
    tick(1);
    req_valid = '0;
    dma_done = 1'b0;
    chk("ps_start0", 64'(dma_start), 64'h1);
    chk("ps_grant0", 64'(grant_id), 64'h0);
    tick(2);
    dma_done = 1'b1;
    tick(1);
    chk("ps_cpl0", 64'(cpl_valid), 64'h1);
    tick(1);
    set_ch(2, 32'h9000, 32'hA000, 4'd1);
    req_valid = 4'b0101;
    #1;
    chk("ps_ready_skip", 64'(req_ready), 64'h4);
    tick(1);
    req_valid = 4'b0001;
    dma_done = 1'b0;
    chk("ps_grant2", 64'(grant_id), 64'h2);
    chk("ps_src2", 64'(dma_src), 64'h9000);
    chk("ps_ready_held", 64'(req_ready), 64'h0);
    tick(2);
    dma_done = 1'b1;
    tick(1);
    chk("ps_cpl2", 64'(cpl_valid), 64'h4);
    tick(1);
    #1;
    chk("ps_ready_wrap", 64'(req_ready), 64'h1);
    tick(1);
    req_valid = '0;
    dma_done = 1'b0;
    chk("ps_grant_wrap", 64'(grant_id), 64'h0);
    chk("ps_src_wrap", 64'(dma_src), 64'h7000);
    tick(2);
    dma_done = 1'b1;
    tick(1);
    chk("ps_cpl_wrap", 64'(cpl_valid), 64'h1);
    tick(1);

    // Timeout on ch1 with done never asserted: cpl_err at T+11
    set_ch(1, 32'hB000, 32'hC000, 4'd5);
    req_valid = 4'b0010;
    #1;
    chk("to_ready", 64'(req_ready), 64'h2);
    tick(1);
    req_valid = '0;
    dma_done = 1'b0;
    chk("to_start", 64'(dma_start), 64'h1);
    tick(9);
    chk("to_no_cpl_t10", 64'(cpl_valid), 64'h0);
    chk("to_busy_t10", 64'(busy), 64'h1);
    tick(1);
    chk("to_cpl_t11", 64'(cpl_valid), 64'h2);
    chk("to_err_t11", 64'(cpl_err), 64'h1);
    tick(1);
    chk("to_idle", 64'(busy), 64'h0);
    chk("to_err_clear", 64'(cpl_err), 64'h0);

    // Reset mid-WAIT
    set_ch(2, 32'hD000, 32'hE000, 4'd3);
    req_valid = 4'b0100;
    #1;
    chk("rw_ready", 64'(req_ready), 64'h4);
    tick(1);
    req_valid = '0;
    tick(2);
    chk("rw_busy_wait", 64'(busy), 64'h1);
    chk("rw_src_wait", 64'(dma_src), 64'hD000);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rw");
    tick(2);
    chk("rw_cpl_hold", 64'(cpl_valid), 64'h0);
    rst_n = 1'b1;

    // Round-robin with all channels valid, starting from rr_ptr 0 after reset
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 32'h10 + 32'h100 * c, 32'h20 + 32'h100 * c, 4'd0);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << rr_exp[i];
      #1;
      chk("rr_ready", 64'(req_ready), 64'(oh));
      tick(1);
      chk("rr_cpl", 64'(cpl_valid), 64'(oh));
      chk("rr_grant", 64'(grant_id), 64'(rr_exp[i]));
      chk("rr_src", 64'(dma_src), 64'(32'h10 + 32'h100 * rr_exp[i]));
      tick(1);
    end
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
